// File: rtl/stack_pkg.sv
// Shared constants and types for the single-bit LIFO: default depth,
// count-width helper and the per-cycle operation encoding.
package stack_pkg;

    localparam int STACK_DEPTH = 8;

    // Count must represent 0..depth inclusive, hence depth+1 states.
    function automatic int ptr_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_e;

endpackage : stack_pkg

// File: rtl/stack_1bit_mem.sv
// DEPTH x 1 register file: one synchronous write port and one asynchronous
// read port. The top level drives the read address with count-1.
module stack_1bit_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic          wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic          rdata_o
);

    logic mem_q [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the count register,
    // so clearing the array would only cost reset fan-out.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // An empty stack addresses count-1 = all ones, which lies outside the array
    // for non-power-of-two depths; the top level ignores the value when empty.
    assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : 1'b0;

endmodule : stack_1bit_mem

// File: rtl/stack_1bit.sv
// Single-bit LIFO with registered pop output, full/empty status and
// one-cycle overflow/underflow pulses.
module stack_1bit
    import stack_pkg::*;
#(
    parameter  int DEPTH = STACK_DEPTH,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             data,
    input  logic             push,
    input  logic             pop,
    output logic             D_out,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [PTR_W-1:0] count_q, count_d;
    logic             dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    stack_op_e        op;
    logic             full_w, empty_w;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    top_addr;
    logic             top_bit;

    assign full_w   = (count_q == PTR_W'(DEPTH));
    assign empty_w  = (count_q == '0);
    assign top_addr = AW'(count_q - PTR_W'(1));

    stack_1bit_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .CLK     (CLK),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (data),
        .raddr_i (top_addr),
        .rdata_o (top_bit)
    );

    // Push together with pop on an empty stack degrades to a plain push.
    always_comb begin
        op = OP_NOP;
        if (push && pop && !empty_w) begin
            op = OP_REPLACE;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        count_d   = count_q;
        dout_d    = dout_q;
        ovf_d     = 1'b0;
        udf_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = AW'(count_q);
        unique case (op)
            OP_PUSH: begin
                udf_d = pop;
                if (full_w) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    count_d = count_q + PTR_W'(1);
                end
            end
            OP_POP: begin
                if (empty_w) begin
                    udf_d = 1'b1;
                end else begin
                    dout_d  = top_bit;
                    count_d = count_q - PTR_W'(1);
                end
            end
            OP_REPLACE: begin
                dout_d    = top_bit;
                mem_we    = 1'b1;
                mem_waddr = top_addr;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            dout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign D_out     = dout_q;
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule : stack_1bit

// File: tb/tb_stack_1bit.sv
// Self-checking bench for stack_1bit: directed scenarios plus randomized
// traffic compared against a queue-based LIFO model.
module tb_stack_1bit;
    import stack_pkg::*;

    localparam int DEPTH = STACK_DEPTH;
    localparam int PTR_W = ptr_w(DEPTH);

    logic             CLK;
    logic             RST;
    logic             data;
    logic             push;
    logic             pop;
    logic             D_out;
    logic             full;
    logic             empty;
    logic [PTR_W-1:0] count;
    logic             overflow;
    logic             underflow;

    int n_cmp;
    int n_mis;

    bit mdl_q[$];
    bit mdl_dout;
    bit mdl_ovf;
    bit mdl_udf;

    stack_1bit #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .data      (data),
        .push      (push),
        .pop       (pop),
        .D_out     (D_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference LIFO: back of the queue is the top of the stack.
    task automatic model_apply(input bit p, input bit o, input bit d);
        mdl_ovf = 1'b0;
        mdl_udf = 1'b0;
        if (p && o && mdl_q.size() > 0) begin
            mdl_dout = mdl_q[mdl_q.size() - 1];
            mdl_q[mdl_q.size() - 1] = d;
        end else if (p) begin
            if (o) mdl_udf = 1'b1;
            if (mdl_q.size() == DEPTH) mdl_ovf = 1'b1;
            else mdl_q.push_back(d);
        end else if (o) begin
            if (mdl_q.size() == 0) mdl_udf = 1'b1;
            else mdl_dout = mdl_q.pop_back();
        end
    endtask

    task automatic model_reset();
        mdl_q.delete();
        mdl_dout = 1'b0;
        mdl_ovf  = 1'b0;
        mdl_udf  = 1'b0;
    endtask

    task automatic check_all();
        check("count", 32'(count), 32'(mdl_q.size()));
        check("full", 32'(full), 32'(mdl_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(mdl_q.size() == 0));
        check("d_out", 32'(D_out), 32'(mdl_dout));
        check("overflow", 32'(overflow), 32'(mdl_ovf));
        check("underflow", 32'(underflow), 32'(mdl_udf));
    endtask

    task automatic step(input bit p, input bit o, input bit d);
        @(negedge CLK);
        push = p;
        pop  = o;
        data = d;
        @(posedge CLK);
        model_apply(p, o, d);
        #1;
        check_all();
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(D_out), 32'd0);
        check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        @(negedge CLK);
        RST  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        data = 1'b0;
    endtask

    initial begin
        logic seq_in  [7];
        logic seq_exp [6];
        seq_in  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        seq_exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        n_cmp = 0;
        n_mis = 0;
        RST   = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        data  = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge CLK);
        RST = 1'b0;

        // Pop on empty after reset.
        step(1'b0, 1'b1, 1'b0);
        check("udf_pulse", 32'(underflow), 32'd1);
        check("udf_dout", 32'(D_out), 32'd0);
        step(1'b0, 1'b0, 1'b0);

        // Seven pushes then six pops.
        foreach (seq_in[i]) step(1'b1, 1'b0, seq_in[i]);
        foreach (seq_exp[i]) begin
            step(1'b0, 1'b1, 1'b0);
            check("seq_dout", 32'(D_out), 32'(seq_exp[i]));
        end
        check("seq_count", 32'(count), 32'd1);
        check("seq_empty", 32'(empty), 32'd0);
        do_reset();

        // Fill, overflow, drain.
        repeat (DEPTH) step(1'b1, 1'b0, 1'b1);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'(DEPTH));
        step(1'b1, 1'b0, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'(DEPTH));
        repeat (DEPTH) begin
            step(1'b0, 1'b1, 1'b0);
            check("drain_dout", 32'(D_out), 32'd1);
        end
        check("drain_empty", 32'(empty), 32'd1);
        do_reset();

        // Replace-top.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("repl_dout", 32'(D_out), 32'd0);
        check("repl_count", 32'(count), 32'd2);
        step(1'b0, 1'b1, 1'b0);
        check("repl_pop", 32'(D_out), 32'd1);
        do_reset();

        // Asynchronous reset mid-operation.
        repeat (3) step(1'b1, 1'b0, 1'b1);
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        check("post_rst_udf", 32'(underflow), 32'd1);

        // Push held high across three edges.
        do_reset();
        @(negedge CLK);
        push = 1'b1;
        data = 1'b1;
        repeat (3) begin
            @(posedge CLK);
            model_apply(1'b1, 1'b0, 1'b1);
            #1;
            check_all();
        end
        check("level_count", 32'(count), 32'd3);
        step(1'b0, 1'b0, 1'b0);

        // Randomized traffic in phases biased toward filling or draining.
        for (int i = 0; i < 3000; i++) begin
            int push_pct;
            push_pct = ((i / 100) % 2 == 0) ? 70 : 30;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < push_pct,
                     $urandom_range(0, 99) >= push_pct,
                     1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_stack_1bit
